xor_gate_selftest_ctrl: RTL and testbench
=========================================

Name: xor_gate_selftest_ctrl

Overview:
- Sequencing controller that exhaustively exercises a 2-input XOR gate instance (the NAND-built XOR cell) in hardware.
- On a start request it drives all four input vectors (00, 01, 10, 11), waits a programmable settle time for each, and compares the gate output against a^b.
- Reports busy/done, a pass flag and a mismatch count.
- Sits beside the gate instance as its on-chip self-test / stimulus owner.

Parameters:
- SETTLE_CYCLES, 2, clock cycles each vector is held before its output is sampled; legal range 1..15.
- ERR_W, 3, width of the mismatch counter; the counter saturates at 2^ERR_W-1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled only when not busy.
- abort  input  1  cancels a run in progress.
- dut_y  input  1  output of the gate under test (combinational from dut_a/dut_b).
- dut_a  output  1  registered gate input a.
- dut_b  output  1  registered gate input b.
- busy  output  1  high while a sweep is running.
- done  output  1  high after a sweep completes; held until the next accepted start, an abort, or rst.
- pass  output  1  valid while done=1; 1 when err_count==0.
- err_count  output  ERR_W  number of mismatches in the last sweep, saturating.

Behaviour:
- Reset values (asynchronous, immediate on rst=1): state IDLE, dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0, vector index=0, settle counter=0.
- States:
  - IDLE: no sweep in progress.
  - RUN: vector applied, settle counter running.
  - DONE: sweep complete, results held.
- Start acceptance: start=1 in IDLE or DONE (and abort=0) at edge k.
  - Next state RUN; vec=0; dut_a/dut_b=00; err_count=0; done=0; pass=0; busy=1; settle counter=SETTLE_CYCLES-1.
- RUN:
  - Counter decrements each edge while nonzero.
  - On the edge where the counter is 0, dut_y is compared with vec[1]^vec[0]; on mismatch err_count increments unless already at its maximum.
  - On that same edge:
    - If vec<3: vec increments, dut_a/dut_b take the new vector, and the counter reloads to SETTLE_CYCLES-1.
    - If vec==3: go to DONE; busy=0; done=1; pass=1 only if no mismatch occurred, including this final compare. dut_a/dut_b return to 00.
- Timing: vector i is applied at edge k+i*SETTLE_CYCLES and sampled at edge k+(i+1)*SETTLE_CYCLES. done rises at edge k+4*SETTLE_CYCLES. busy is high for exactly 4*SETTLE_CYCLES cycles.
- start while busy is ignored; no queuing.
- abort=1 in RUN: next edge goes to IDLE with busy=0, done=0, pass=0, dut_a/dut_b=00. err_count keeps its partial value.
- abort=1 in IDLE or DONE: go to IDLE with done=0 and pass=0. abort takes priority over a simultaneous start.
- rst mid-sweep: all outputs return to reset values immediately; a new start is required afterwards.
- Saturation: with ERR_W=2 an XNOR gate (4 mismatches) reports err_count=3.

Optional Feature:
- Macro XOR_SELFTEST_FAIL_CAPTURE_EN.
- When defined, two extra outputs are added:
  - fail_vec[1:0]: the {a,b} vector of the first mismatch in the current sweep.
  - fail_valid: set on that first mismatch.
- Both are cleared on accepted start, on abort, and on rst. Later mismatches do not overwrite fail_vec.
- When undefined, neither port nor the capture logic exists, and the rest of the behaviour is identical.

Test Plan:
1. Correct XOR model on dut_y, SETTLE_CYCLES=2, one-cycle start pulse -> dut_a/dut_b sequence 00,01,10,11, each held 2 cycles; busy high for 8 cycles; then done=1, pass=1, err_count=0, dut_a/dut_b=00.
2. dut_y stuck at 0 -> err_count=2 (vectors 01 and 10), pass=0, done=1.
3. AND model on dut_y with ERR_W=2 -> err_count=3, pass=0. XNOR model with ERR_W=2 -> err_count saturates at 3, not 0.
4. abort asserted 3 cycles after start -> next edge busy=0, done=0, dut_a/dut_b=00. A following start runs a full 8-cycle sweep and finishes with pass=1.
5. rst asserted mid-sweep (asynchronously, between edges) -> outputs are at reset values immediately. A start pulse during busy is ignored, and the sweep ends at the original done cycle.
6. With XOR_SELFTEST_FAIL_CAPTURE_EN defined and an AND model -> fail_valid=1 and fail_vec=01 from the second sample edge onward, unchanged through done.

Source files
------------

// File: rtl/xor_gate_selftest_ctrl.sv
// xor_gate_selftest_ctrl
// On-chip self-test sequencer for a 2-input XOR cell. A run applies the
// vectors 00, 01, 10 and 11 to the gate, lets each one settle for
// SETTLE_CYCLES clocks, and compares the gate output against a^b. The
// result is reported as done/pass plus a saturating mismatch count.
//
// Optional build macro: XOR_SELFTEST_FAIL_CAPTURE_EN
//   Adds fail_vec/fail_valid, which record the {a,b} vector of the first
//   mismatch in the current sweep.
//
// Request handshake: start is a request that is taken on a rising clock
// edge only while busy=0 and abort=0; busy=1 on the following cycle is the
// acknowledgement. There is no queuing, so a start seen while busy is
// dropped. abort is a level that wins over start on the same edge.

module xor_gate_selftest_ctrl #(
  parameter int SETTLE_CYCLES = 2,  // legal range 1..15
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_y,
  output logic             dut_a,
  output logic             dut_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
`ifdef XOR_SELFTEST_FAIL_CAPTURE_EN
  output logic [1:0]       fail_vec,
  output logic             fail_valid,
`endif
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The settle counter is sized for the largest legal SETTLE_CYCLES (15).
  localparam int               CNT_W         = 4;
  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX       = '1;

  state_t           state;
  logic [1:0]       vec;
  logic [CNT_W-1:0] settle_cnt;

  logic             exp_y;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;
  logic [1:0]       vec_next;
  logic             last_vec;
  logic             sample_now;

  // Debug view of the controller state for checkers and bring-up.
  assign state_dbg = state;

  // Compare path: reference value for the current vector and the count
  // that results if this cycle turns out to be a sample cycle.
  always_comb begin
    exp_y      = vec[1] ^ vec[0];
    mismatch   = (dut_y != exp_y);
    sample_now = (state == ST_RUN) && (settle_cnt == '0);
    last_vec   = (vec == 2'd3);
    vec_next   = vec + 2'd1;
    err_next   = err_count;
    if (mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + ERR_W'(1);
    end
  end

  // Sweep controller: state, gate stimulus, settle timing and results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      vec        <= 2'd0;
      settle_cnt <= '0;
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
`ifdef XOR_SELFTEST_FAIL_CAPTURE_EN
      fail_vec   <= 2'd0;
      fail_valid <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (abort) begin
            // Abort while idle or holding results just drops the result
            // flags; the last mismatch count stays readable.
            state <= ST_IDLE;
            done  <= 1'b0;
            pass  <= 1'b0;
`ifdef XOR_SELFTEST_FAIL_CAPTURE_EN
            fail_vec   <= 2'd0;
            fail_valid <= 1'b0;
`endif
          end else if (start) begin
            // Accept the request and apply vector 00 on this same edge.
            state      <= ST_RUN;
            vec        <= 2'd0;
            settle_cnt <= SETTLE_RELOAD;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
`ifdef XOR_SELFTEST_FAIL_CAPTURE_EN
            fail_vec   <= 2'd0;
            fail_valid <= 1'b0;
`endif
          end
        end

        ST_RUN: begin
          if (abort) begin
            // Cancel: park the gate inputs, keep the partial count.
            state      <= ST_IDLE;
            vec        <= 2'd0;
            settle_cnt <= '0;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
`ifdef XOR_SELFTEST_FAIL_CAPTURE_EN
            fail_vec   <= 2'd0;
            fail_valid <= 1'b0;
`endif
          end else if (!sample_now) begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end else begin
            // Settle time has elapsed: judge the current vector.
            err_count <= err_next;
`ifdef XOR_SELFTEST_FAIL_CAPTURE_EN
            if (mismatch && !fail_valid) begin
              fail_vec   <= vec;
              fail_valid <= 1'b1;
            end
`endif
            if (!last_vec) begin
              vec        <= vec_next;
              dut_a      <= vec_next[1];
              dut_b      <= vec_next[0];
              settle_cnt <= SETTLE_RELOAD;
            end else begin
              // Final vector judged; pass needs a clean sweep including
              // this last compare.
              state      <= ST_DONE;
              vec        <= 2'd0;
              dut_a      <= 1'b0;
              dut_b      <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              pass       <= (err_count == '0) && !mismatch;
            end
          end
        end

        default: begin
          state      <= ST_IDLE;
          vec        <= 2'd0;
          settle_cnt <= '0;
          dut_a      <= 1'b0;
          dut_b      <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          pass       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_gate_selftest_ctrl.sv
// Testbench for xor_gate_selftest_ctrl. The gate under test is modelled as
// a 4-entry truth table indexed by {a,b}, so XOR, stuck-at, AND, XNOR and
// random faulty gates are all just different tables. Expected outputs come
// from a sweep-timeline model: vector i is live for cycles [i*S, (i+1)*S)
// after acceptance and judged at offset (i+1)*S.
// Build with +define+XOR_SELFTEST_FAIL_CAPTURE_EN to cover the capture port.

module tb_xor_gate_selftest_ctrl;

  localparam int S    = 2;
  localparam int EW   = 2;
  localparam int EMAX = (1 << EW) - 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;

  always #5 clk = ~clk;

  logic          dut_a, dut_b, busy, done, pass;
  logic [EW-1:0] err_count;
  logic [1:0]    state_dbg;
  logic [3:0]    tt = 4'b0110;
  logic          dut_y;
`ifdef XOR_SELFTEST_FAIL_CAPTURE_EN
  logic [1:0]    fail_vec;
  logic          fail_valid;
`endif

  // Gate model: truth table lookup on the applied vector.
  assign dut_y = tt[{dut_a, dut_b}];

  xor_gate_selftest_ctrl #(
    .SETTLE_CYCLES(S),
    .ERR_W        (EW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .dut_y     (dut_y),
    .dut_a     (dut_a),
    .dut_b     (dut_b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
`ifdef XOR_SELFTEST_FAIL_CAPTURE_EN
    .fail_vec  (fail_vec),
    .fail_valid(fail_valid),
`endif
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Does the gate described by table m get vector j wrong?
  function automatic bit is_bad(input logic [3:0] m, input int j);
    return m[j] != 1'((j ^ (j >> 1)) & 1);
  endfunction

  // Raw mismatch count over vectors whose judge point is at or before upto.
  function automatic int bad_upto(input logic [3:0] m, input int upto);
    int n = 0;
    for (int j = 0; j < 4; j++) if ((j + 1) * S <= upto && is_bad(m, j)) n++;
    return n;
  endfunction

  function automatic int sat(input int n);
    return (n > EMAX) ? EMAX : n;
  endfunction

  function automatic int first_bad(input logic [3:0] m);
    for (int j = 0; j < 4; j++) if (is_bad(m, j)) return j;
    return -1;
  endfunction

  // Expected outputs at offset t cycles after the accepting edge.
  task automatic check_point(input logic [3:0] m, input int t);
    int fb;
    bit fv;
    check("busy", busy, (t < 4 * S) ? 1 : 0);
    check("done", done, (t == 4 * S) ? 1 : 0);
    check("pass", pass, (t == 4 * S && bad_upto(m, t) == 0) ? 1 : 0);
    check("vec",  {dut_a, dut_b}, (t < 4 * S) ? t / S : 0);
    check("err",  err_count, sat(bad_upto(m, t)));
`ifdef XOR_SELFTEST_FAIL_CAPTURE_EN
    fb = first_bad(m);
    fv = (fb >= 0) && (t >= (fb + 1) * S);
    check("fail_valid", fail_valid, fv);
    check("fail_vec",   fail_vec, fv ? fb : 0);
`else
    fb = 0;
    fv = 1'b0;
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"},  err_count, 0);
    check({tag, "_vec"},  {dut_a, dut_b}, 0);
`ifdef XOR_SELFTEST_FAIL_CAPTURE_EN
    check({tag, "_fvalid"}, fail_valid, 0);
    check({tag, "_fvec"},   fail_vec, 0);
`endif
  endtask

  // ---------------- driver ----------------
  // Runs one sweep with gate table m. abort_at / rst_at give the cycle
  // offset at which the event hits (-1 = never); extra_start_at pulses a
  // start while busy (must be ignored).
  task automatic sweep(input logic [3:0] m, input int abort_at,
                       input int extra_start_at, input int rst_at);
    tt = m;
    @(negedge clk); start = 1'b1; abort = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int t = 0; t <= 4 * S; t++) begin
      if (abort_at == t) begin
        // Abort edge: no judgement happens on it.
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pass", pass, 0);
        check("abort_vec",  {dut_a, dut_b}, 0);
        check("abort_err",  err_count, sat(bad_upto(m, t - 1)));
`ifdef XOR_SELFTEST_FAIL_CAPTURE_EN
        check("abort_fvalid", fail_valid, 0);
`endif
        return;
      end
      check_point(m, t);
      if (rst_at == t) begin
        #2 rst = 1'b1;
        #1 check_reset_vals("rst_mid");
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_after");
        return;
      end
      start = (t == extra_start_at);
      abort = (t + 1 == abort_at);
      if (t < 4 * S) @(negedge clk);
    end
    start = 1'b0;
    // Results must hold while idle.
    @(negedge clk);
    check("done_hold", done, 1);
    check("err_hold",  err_count, sat(bad_upto(m, 4 * S)));
    exp_q.push_back(32'(sat(bad_upto(m, 4 * S))));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    sweep(4'b0110, -1, -1, -1);   // correct XOR
    sweep(4'b0000, -1, -1, -1);   // stuck at 0 -> 2 errors
    sweep(4'b1000, -1, -1, -1);   // AND -> 3 errors, first fail 01
    sweep(4'b1001, -1, -1, -1);   // XNOR -> 4 errors, saturates at 3

    // Abort while holding results: flags clear, count stays.
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_done_done", done, 0);
    check("abort_done_pass", pass, 0);
    check("abort_done_err",  err_count, exp_q[$]);

    sweep(4'b0110, 3, -1, -1);    // abort 3 cycles into a sweep
    sweep(4'b0110, -1, -1, -1);   // next start runs a full clean sweep
    sweep(4'b1000, -1, -1, 5);    // async reset mid-sweep
    sweep(4'b0000, -1, 3, -1);    // start while busy is ignored

    // abort wins over a simultaneous start.
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("abort_prio_busy", busy, 0);
    check("abort_prio_done", done, 0);

    // Randomised gates and disturbance events.
    for (int i = 0; i < 24; i++) begin
      logic [3:0] m;
      int kind;
      m    = 4'($urandom_range(0, 15));
      kind = $urandom_range(0, 3);
      case (kind)
        1:       sweep(m, -1, $urandom_range(0, 4 * S - 1), -1);
        2:       sweep(m, $urandom_range(1, 4 * S), -1, -1);
        3:       sweep(m, -1, -1, $urandom_range(0, 4 * S));
        default: sweep(m, -1, -1, -1);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the whole run is a few thousand cycles.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
